// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and one-hot decode helper for the register file
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    localparam logic [31:0] EN_RESET = 32'h0000_0001;
    function automatic logic [31:0] onehot(input logic [4:0] addr);
        return 32'd1 << addr;
    endfunction
endpackage

// File: rtl/regfile_core_decoder.sv
// decoder_5to32: 5-bit address to gated 32-bit one-hot vector
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic        en,
    output logic [31:0] dec
);
    always_comb dec = en ? onehot(addr) : '0;
endmodule

// File: rtl/regfile_core.sv
// regfile_core: 32x32 register storage with write decode and registered one-hot read enables
module regfile_core #(
    parameter int XLEN = 32,
    parameter int NUM_REGS = 32,
    parameter bit ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     ctrl_writeEnable,
    input  logic [4:0]               ctrl_writeReg,
    input  logic [XLEN-1:0]          data_writeReg,
    input  logic [4:0]               ctrl_readRegA,
    input  logic [4:0]               ctrl_readRegB,
    input  logic                     ctrl_holdRead,
    output logic [XLEN*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]      tri_EN_A,
    output logic [NUM_REGS-1:0]      tri_EN_B,
    output logic [NUM_REGS-1:0]      wr_onehot
);
    import regfile_pkg::*;
    logic [NUM_REGS-1:0] dec_a;
    logic [NUM_REGS-1:0] dec_b;
    decoder_5to32 u_dec_wr (.addr(ctrl_writeReg), .en(ctrl_writeEnable), .dec(wr_onehot));
    decoder_5to32 u_dec_a (.addr(ctrl_readRegA), .en(1'b1), .dec(dec_a));
    decoder_5to32 u_dec_b (.addr(ctrl_readRegB), .en(1'b1), .dec(dec_b));
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (ZERO_REG && i == 0) begin : g_zero
            assign reg_q[i*XLEN +: XLEN] = '0;
        end else begin : g_ff
            logic [XLEN-1:0] q;
            always_ff @(posedge clock) begin
                if (ctrl_reset) q <= '0;
                else if (wr_onehot[i]) q <= data_writeReg;
            end
            assign reg_q[i*XLEN +: XLEN] = q;
        end
    end
    // Reset parks both buses on register 0 so they are never undriven.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            tri_EN_A <= EN_RESET;
            tri_EN_B <= EN_RESET;
        end else if (!ctrl_holdRead) begin
            tri_EN_A <= dec_a;
            tri_EN_B <= dec_b;
        end
    end
endmodule
